// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - multi-cycle ALU control sequencer with accumulator
//
// Steps the SAP-style ALU through EXEC -> FLAG -> READ for each accepted
// request and holds the captured result until it is consumed.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/req_ready request handshake; req_op 00 ADD, 01 SUB, 10 CMP, 11 ACC
//   req_a, req_b        operands (req_a ignored for ACC, which uses the accumulator)
//   sw_clr              soft clear, honoured only while idle
//   rsp_valid/rsp_ready response handshake; rsp_data, rsp_cf, rsp_zf result
//   op_count            completed-response counter (wraps)
//   alu_a, alu_b        ALU operand drive
//   alu_su, alu_fi      ALU subtract select, flag-register load
//   alu_eo, alu_clr     ALU bus output enable, ALU clear
//   alu_bus, alu_cf/zf  ALU bus result and registered flags
module alu_op_sequencer #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             sw_clr,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_cf,
  output logic             rsp_zf,
  output logic [15:0]      op_count,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_su,
  output logic             alu_fi,
  output logic             alu_eo,
  output logic             alu_clr,
  input  logic [WIDTH-1:0] alu_bus,
  input  logic             alu_cf,
  input  logic             alu_zf
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_EXEC = 3'd1;
  localparam logic [2:0] ST_FLAG = 3'd2;
  localparam logic [2:0] ST_READ = 3'd3;
  localparam logic [2:0] ST_RESP = 3'd4;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_CMP = 2'b10;
  localparam logic [1:0] OP_ACC = 2'b11;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  logic [2:0]       state;
  logic [3:0]       settle_cnt;
  logic [1:0]       op;
  logic [WIDTH-1:0] acc;

  // A pending clear blocks acceptance so clear always wins a collision.
  assign req_ready = (state == ST_IDLE) && !sw_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      op         <= OP_ADD;
      acc        <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_su     <= 1'b0;
      alu_fi     <= 1'b0;
      alu_eo     <= 1'b0;
      alu_clr    <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_cf     <= 1'b0;
      rsp_zf     <= 1'b0;
      op_count   <= '0;
    end else begin
      // Strobes are single-cycle; they are re-armed only on the state entry below.
      alu_fi  <= 1'b0;
      alu_eo  <= 1'b0;
      alu_clr <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sw_clr) begin
            alu_clr <= 1'b1;
            acc     <= '0;
          end else if (req_valid) begin
            alu_a      <= (req_op == OP_ACC) ? acc : req_a;
            alu_b      <= req_b;
            alu_su     <= (req_op == OP_SUB) || (req_op == OP_CMP);
            op         <= req_op;
            settle_cnt <= SETTLE_LOAD;
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (settle_cnt <= 4'd1) begin
            alu_fi <= 1'b1;
            state  <= ST_FLAG;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        ST_FLAG: begin
          // Flags were latched by the ALU at the end of FLAG; drive the bus next.
          alu_eo <= 1'b1;
          state  <= ST_READ;
        end
        ST_READ: begin
          rsp_data  <= alu_bus;
          rsp_cf    <= alu_cf;
          rsp_zf    <= alu_zf;
          rsp_valid <= 1'b1;
          if (op != OP_CMP) begin
            acc <= alu_bus;
          end
          state <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + 16'd1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - randomized self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;

  localparam int W = 8;
  localparam int S = 3;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_CMP = 2'b10;
  localparam logic [1:0] OP_ACC = 2'b11;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [1:0]   req_op = 2'b00;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic         sw_clr = 1'b0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_data;
  logic         rsp_cf, rsp_zf;
  logic [15:0]  op_count;
  logic [W-1:0] alu_a, alu_b;
  logic         alu_su, alu_fi, alu_eo, alu_clr;
  logic [W-1:0] alu_bus;
  logic         alu_cf, alu_zf;

  int checks = 0;
  int failures = 0;
  int model_acc = 0;
  int model_count = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .sw_clr(sw_clr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_cf(rsp_cf), .rsp_zf(rsp_zf), .op_count(op_count),
    .alu_a(alu_a), .alu_b(alu_b), .alu_su(alu_su), .alu_fi(alu_fi),
    .alu_eo(alu_eo), .alu_clr(alu_clr), .alu_bus(alu_bus),
    .alu_cf(alu_cf), .alu_zf(alu_zf)
  );

  // SAP-style ALU: subtract is A + ~B + 1, flags registered on FI, bus driven only on EO.
  logic [W:0] alu_sum;
  assign alu_sum = alu_su ? ({1'b0, alu_a} + {1'b0, ~alu_b} + (W+1)'(1))
                          : ({1'b0, alu_a} + {1'b0, alu_b});
  assign alu_bus = alu_eo ? alu_sum[W-1:0] : '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_cf <= 1'b0;
      alu_zf <= 1'b0;
    end else if (alu_clr) begin
      alu_cf <= 1'b0;
      alu_zf <= 1'b0;
    end else if (alu_fi) begin
      alu_cf <= alu_sum[W];
      alu_zf <= (alu_sum[W-1:0] == '0);
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Arithmetic view of one operation; updates the model accumulator.
  function automatic void ref_op(input logic [1:0] op, input int a, input int b,
                                 output int data, output int cf, output int zf);
    int opa;
    int r;
    opa = (op == OP_ACC) ? model_acc : a;
    if (op == OP_SUB || op == OP_CMP) begin
      r  = opa - b;
      cf = (opa >= b) ? 1 : 0;
    end else begin
      r  = opa + b;
      cf = (r >= (1 << W)) ? 1 : 0;
    end
    data = r & ((1 << W) - 1);
    zf   = (data == 0) ? 1 : 0;
    if (op != OP_CMP) model_acc = data;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output bit ok);
    ok = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
    #1;
    for (int i = 0; i < 50; i++) begin
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      check("req_accept_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold);
    int exp_a, exp_d, exp_c, exp_z;
    bit ok;
    exp_a = (op == OP_ACC) ? model_acc : int'(a);
    ref_op(op, a, b, exp_d, exp_c, exp_z);
    issue(op, a, b, ok);
    if (!ok) return;
    for (int k = 0; k < S + 2; k++) begin
      @(negedge clk);
      check("alu_fi", alu_fi, (k == S) ? 1 : 0);
      check("alu_eo", alu_eo, (k == S + 1) ? 1 : 0);
      check("rsp_valid_early", rsp_valid, 0);
      check("alu_a", alu_a, exp_a);
      check("alu_b", alu_b, b);
      check("alu_su", alu_su, (op == OP_SUB || op == OP_CMP) ? 1 : 0);
    end
    @(negedge clk);
    check("rsp_valid", rsp_valid, 1);
    check("rsp_data", rsp_data, exp_d);
    check("rsp_cf", rsp_cf, exp_c);
    check("rsp_zf", rsp_zf, exp_z);
    req_valid = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("bp_req_ready", req_ready, 0);
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_data", rsp_data, exp_d);
      check("bp_flags", {rsp_cf, rsp_zf}, {exp_c[0], exp_z[0]});
      check("bp_strobes", {alu_fi, alu_eo}, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    model_count = (model_count + 1) & 16'hFFFF;
    @(negedge clk);
    check("rsp_valid_drop", rsp_valid, 0);
    check("op_count", op_count, model_count);
  endtask

  task automatic soft_clear();
    logic [W-1:0] a_before;
    @(negedge clk);
    a_before = alu_a;
    sw_clr = 1'b1;
    req_valid = 1'b1;
    req_op = OP_ADD;
    #1 check("clr_req_ready", req_ready, 0);
    @(negedge clk);
    check("clr_pulse", alu_clr, 1);
    check("clr_alu_a_kept", alu_a, a_before);
    sw_clr = 1'b0;
    req_valid = 1'b0;
    model_acc = 0;
    #1 check("clr_ready_after", req_ready, 1);
    @(negedge clk);
    check("clr_pulse_end", alu_clr, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    bit ok;
    logic [1:0] rop;
    logic [W-1:0] ra, rb;

    @(negedge clk);
    check("rst_outputs", {rsp_valid, rsp_cf, rsp_zf, alu_su, alu_fi, alu_eo, alu_clr}, 0);
    check("rst_data", {rsp_data, alu_a, alu_b}, 0);
    check("rst_op_count", op_count, 0);
    check("rst_req_ready", req_ready, 1);
    rst_n = 1'b1;

    run_op(OP_ADD, 8'h12, 8'h34, 0);
    run_op(OP_SUB, 8'h05, 8'h05, 0);
    run_op(OP_ADD, 8'h80, 8'h70, 0);
    run_op(OP_ACC, 8'hAA, 8'h20, 0);
    run_op(OP_CMP, 8'h10, 8'h10, 0);
    run_op(OP_ACC, 8'h55, 8'h00, 0);
    run_op(OP_SUB, 8'h03, 8'h09, 10);
    soft_clear();
    run_op(OP_ACC, 8'h77, 8'h05, 0);

    // Asynchronous reset while the sequencer sits in FLAG.
    issue(OP_ADD, 8'h33, 8'h44, ok);
    repeat (S + 1) @(negedge clk);
    check("pre_rst_fi", alu_fi, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_strobes", {alu_fi, alu_eo, alu_clr, alu_su, rsp_valid}, 0);
    check("arst_operands", {alu_a, alu_b}, 0);
    check("arst_rsp", {rsp_data, rsp_cf, rsp_zf}, 0);
    check("arst_op_count", op_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_acc = 0;
    model_count = 0;
    run_op(OP_ADD, 8'h01, 8'h01, 0);
    run_op(OP_ACC, 8'h00, 8'h00, 0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 5) == 0) soft_clear();
      rop = 2'($urandom_range(0, 3));
      ra = W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
      run_op(rop, ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
